// File: rtl/sram_port_initiator.sv
`timescale 1ns/1ps
// sram_port_initiator: initiator side of one SRAM wrapper port.
// Turns a valid/ready request stream into single-cycle CE/WE/WEM/A/D port
// cycles, tracks reads in flight and returns Q through a response FIFO.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. The sender holds its payload stable while valid is high and
// not yet accepted; ready never depends on valid on either interface.
//
// RD_LAT must lie in 1..4, and FIFO_DEPTH must be >= RD_LAT+1.
module sram_port_initiator #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 16,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W-1:0] req_wmask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              CE,
   output logic              WE,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] D,
   output logic [DATA_W-1:0] WEM,
   input  logic [DATA_W-1:0] Q,
   output logic              busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int SUM_W = $clog2(FIFO_DEPTH + RD_LAT + 2);

   logic [RD_LAT:0]   trk;          // one valid bit per read-latency stage
   logic [SUM_W-1:0]  inflight;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic [PTR_W-1:0]  wr_ptr;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [DATA_W-1:0] head_next;
   logic              credit;
   logic              accept;
   logic              rd_accept;
   logic              push;
   logic              pop;

   // Count reads still travelling through the SRAM latency pipeline.
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= RD_LAT; i++) begin
         inflight = inflight + SUM_W'(trk[i]);
      end
   end

   // Credit uses registered state only, so a pop frees a slot one cycle later.
   assign credit    = (SUM_W'(count) + inflight) < SUM_W'(FIFO_DEPTH);
   assign req_ready = credit & RSTN;
   assign accept    = req_valid & req_ready;
   assign rd_accept = accept & ~req_we;
   assign push      = trk[RD_LAT];
   assign pop       = rsp_valid & rsp_ready;
   assign busy      = (inflight != '0) | (count != '0);

   // Port cycle register: CE/WE pulse for one cycle per accepted request.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         CE  <= 1'b0;
         WE  <= 1'b0;
         A   <= '0;
         D   <= '0;
         WEM <= '0;
      end else begin
         CE <= accept;
         WE <= accept & req_we;
         if (accept) begin
            A   <= req_addr;
            D   <= req_we ? req_wdata : '0;
            WEM <= req_we ? req_wmask : '0;
         end
      end
   end

   // Read tracker: a set bit walks to the last stage as Q becomes valid.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         trk <= '0;
      end else begin
         trk <= {trk[RD_LAT-1:0], rd_accept};
      end
   end

   // FIFO next-state: occupancy, read pointer and the next registered head.
   always_comb begin
      rd_ptr_next = rd_ptr;
      if (pop) begin
         rd_ptr_next = (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
      head_next = rsp_data;
      // When the FIFO drains to nothing this edge, the pushed word becomes head.
      if (push && ((count == '0) || ((count == CNT_W'(1)) && pop))) begin
         head_next = Q;
      end else if (count_next != '0) begin
         head_next = mem[rd_ptr_next];
      end
   end

   // FIFO control registers and the registered response outputs.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         count  <= count_next;
         rd_ptr <= rd_ptr_next;
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         rsp_valid <= (count_next != '0);
         rsp_data  <= head_next;
      end
   end

   // FIFO storage captures Q when a tracked read reaches the last stage.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= Q;
      end
   end

   // A push into a full FIFO would mean the credit accounting is broken.
   a_no_overflow : assert property (@(posedge CLK) disable iff (!RSTN)
      !(push && (count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sram_port_initiator.sv
`timescale 1ns/1ps
// Bench for sram_port_initiator: one instance with RD_LAT=1 and one with
// RD_LAT=3, each attached to a behavioural SRAM. A select bit routes the
// request stream to one instance at a time; responses are checked against
// an expected queue filled from a plain array model of the memory.
module tb_sram_port_initiator;

   localparam int AW    = 7;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic rstn    = 1'b0;
   logic sel     = 1'b0;
   logic mem_clr = 1'b1;

   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic          req_valid = 1'b0;
   logic          req_we    = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [DW-1:0] req_wmask = '0;
   logic          rsp_ready = 1'b0;

   logic valid_a;
   logic valid_b;
   assign valid_a = req_valid & ~sel;
   assign valid_b = req_valid & sel;

   // ---------------- instance A (RD_LAT=1) ----------------
   logic          rr_a, rv_a, ce_a, we_a, busy_a;
   logic [DW-1:0] rd_a, d_a, wem_a, q_a;
   logic [AW-1:0] a_a;

   sram_port_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) dut_a (
      .CLK(clk), .RSTN(rstn),
      .req_valid(valid_a), .req_ready(rr_a), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_data(rd_a),
      .CE(ce_a), .WE(we_a), .A(a_a), .D(d_a), .WEM(wem_a), .Q(q_a), .busy(busy_a)
   );

   logic [DW-1:0] sram_a [128];
   logic [DW-1:0] pipe_a;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 128; i++) sram_a[i] <= '0;
      end else if (ce_a && we_a) begin
         sram_a[a_a] <= (sram_a[a_a] & ~wem_a) | (d_a & wem_a);
      end
      pipe_a <= (ce_a && !we_a) ? sram_a[a_a] : 'x;
   end
   assign q_a = pipe_a;

   // ---------------- instance B (RD_LAT=3) ----------------
   logic          rr_b, rv_b, ce_b, we_b, busy_b;
   logic [DW-1:0] rd_b, d_b, wem_b, q_b;
   logic [AW-1:0] a_b;

   sram_port_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .FIFO_DEPTH(DEPTH)) dut_b (
      .CLK(clk), .RSTN(rstn),
      .req_valid(valid_b), .req_ready(rr_b), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_data(rd_b),
      .CE(ce_b), .WE(we_b), .A(a_b), .D(d_b), .WEM(wem_b), .Q(q_b), .busy(busy_b)
   );

   logic [DW-1:0] sram_b [128];
   logic [DW-1:0] pipe_b0, pipe_b1, pipe_b2;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 128; i++) sram_b[i] <= '0;
      end else if (ce_b && we_b) begin
         sram_b[a_b] <= (sram_b[a_b] & ~wem_b) | (d_b & wem_b);
      end
      pipe_b0 <= (ce_b && !we_b) ? sram_b[a_b] : 'x;
      pipe_b1 <= pipe_b0;
      pipe_b2 <= pipe_b1;
   end
   assign q_b = pipe_b2;

   // ---------------- observed view of the selected instance ----------------
   logic          o_req_ready, o_rsp_valid, o_ce, o_we, o_busy;
   logic [DW-1:0] o_rsp_data, o_d, o_wem;
   logic [AW-1:0] o_a;
   assign o_req_ready = sel ? rr_b   : rr_a;
   assign o_rsp_valid = sel ? rv_b   : rv_a;
   assign o_rsp_data  = sel ? rd_b   : rd_a;
   assign o_ce        = sel ? ce_b   : ce_a;
   assign o_we        = sel ? we_b   : we_a;
   assign o_a         = sel ? a_b    : a_a;
   assign o_d         = sel ? d_b    : d_a;
   assign o_wem       = sel ? wem_b  : wem_a;
   assign o_busy      = sel ? busy_b : busy_a;

   // ---------------- scoreboard / reference model ----------------
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] ref_mem [2][128];
   int            n_checks = 0;
   int            n_pass   = 0;
   int            n_fail   = 0;
   int            n_rsp    = 0;
   bit            acc;
   bit            popd;
   logic          busy_at_pop;
   logic [DW-1:0] last_rsp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge what the next rising edge will do.
   task automatic step();
      @(negedge clk);
      acc  = req_valid && o_req_ready;
      popd = o_rsp_valid && rsp_ready;
      if (popd) begin
         busy_at_pop = o_busy;
         last_rsp    = o_rsp_data;
         n_rsp++;
         check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("rsp_data", 32'(o_rsp_data), 32'(exp_q.pop_front()));
      end
      if (acc) begin
         if (req_we)
            ref_mem[sel][req_addr] = (ref_mem[sel][req_addr] & ~req_wmask) | (req_wdata & req_wmask);
         else
            exp_q.push_back(ref_mem[sel][req_addr]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [DW-1:0] mask);
      int budget;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = data;
      req_wmask = mask;
      budget    = 0;
      do begin
         step();
         budget++;
      end while (!acc && budget < 50);
      check("send_accept", 32'(acc), 32'd1);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget    = 0;
      rsp_ready = 1'b1;
      while ((exp_q.size() != 0 || o_busy) && budget < 200) begin
         step();
         budget++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_idle", 32'(o_busy), 32'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + randomized sequence ----------------
   initial begin
      logic [AW-1:0] addrs [20];
      int            n_acc;
      int            idx;
      int            cyc;
      int            budget;

      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 128; i++) ref_mem[s][i] = '0;

      // Reset with a request pending.
      rstn      = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = AW'($urandom_range(0, 127));
      req_wdata = DW'($urandom);
      req_wmask = DW'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ce", 32'(o_ce), 32'd0);
      check("rst_we", 32'(o_we), 32'd0);
      check("rst_req_ready", 32'(o_req_ready), 32'd0);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(o_rsp_data), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      mem_clr   = 1'b0;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(o_req_ready), 32'd1);
      @(posedge clk);
      #1;

      // Write then read the same word, RD_LAT=1.
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 7'h05;
      req_wdata = 16'hA5C3;
      req_wmask = 16'hFFFF;
      step();
      check("wr_accept", 32'(acc), 32'd1);
      check("wr_ce", 32'(o_ce), 32'd1);
      check("wr_we", 32'(o_we), 32'd1);
      check("wr_a", 32'(o_a), 32'h05);
      check("wr_d", 32'(o_d), 32'hA5C3);
      check("wr_wem", 32'(o_wem), 32'hFFFF);
      req_we    = 1'b0;
      req_wdata = DW'($urandom_range(1, 65535));
      req_wmask = DW'($urandom_range(1, 65535));
      step();
      check("rd_accept", 32'(acc), 32'd1);
      check("rd_ce", 32'(o_ce), 32'd1);
      check("rd_we", 32'(o_we), 32'd0);
      check("rd_a", 32'(o_a), 32'h05);
      check("rd_d_zero", 32'(o_d), 32'd0);
      check("rd_wem_zero", 32'(o_wem), 32'd0);
      check("rd_busy", 32'(o_busy), 32'd1);
      check("rd_rsp_valid_0", 32'(o_rsp_valid), 32'd0);
      req_valid = 1'b0;
      step();
      check("idle_ce", 32'(o_ce), 32'd0);
      check("idle_a_hold", 32'(o_a), 32'h05);
      check("rd_rsp_valid_1", 32'(o_rsp_valid), 32'd0);
      step();
      check("rd_rsp_valid_2", 32'(o_rsp_valid), 32'd1);
      check("rd_rsp_data", 32'(o_rsp_data), 32'hA5C3);
      step();
      check("rsp_valid_after_pop", 32'(o_rsp_valid), 32'd0);
      check("busy_after_pop", 32'(o_busy), 32'd0);

      // Masked write.
      send(1'b1, 7'h10, 16'hFFFF, 16'hFFFF);
      send(1'b1, 7'h10, 16'h0000, 16'h00FF);
      send(1'b0, 7'h10, DW'($urandom), DW'($urandom));
      drain();
      check("masked_rsp", 32'(last_rsp), 32'hFF00);

      // Backpressure: six reads into a four-credit initiator.
      for (int i = 0; i < 6; i++) send(1'b1, AW'(i), DW'($urandom), 16'hFFFF);
      rsp_ready = 1'b0;
      n_rsp     = 0;
      n_acc     = 0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = '0;
      repeat (8) begin
         step();
         if (acc) begin
            n_acc++;
            req_addr = AW'(n_acc);
         end
      end
      check("bp_accepted", 32'(n_acc), 32'd4);
      check("bp_ready_low", 32'(o_req_ready), 32'd0);
      check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      budget    = 0;
      while (n_acc < 6 && budget < 20) begin
         step();
         budget++;
         if (acc) begin
            n_acc++;
            req_addr = AW'(n_acc);
         end
      end
      req_valid = 1'b0;
      check("bp_all_accepted", 32'(n_acc), 32'd6);
      drain();
      check("bp_rsp_count", 32'(n_rsp), 32'd6);

      // Wrap and sweep on the RD_LAT=3 instance.
      sel = 1'b1;
      for (int i = 0; i < 20; i++) begin
         addrs[i] = AW'($urandom_range(0, 127));
         send(1'b1, addrs[i], DW'($urandom), DW'($urandom));
      end
      n_rsp     = 0;
      idx       = 0;
      cyc       = 0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = addrs[0];
      while ((idx < 20 || n_rsp < 20) && cyc < 400) begin
         rsp_ready = cyc[0];
         step();
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 20) req_addr = addrs[idx];
            else req_valid = 1'b0;
         end
         if (popd && n_rsp == 20) begin
            check("sweep_busy_before_last", 32'(busy_at_pop), 32'd1);
            check("sweep_busy_fall", 32'(o_busy), 32'd0);
         end
      end
      req_valid = 1'b0;
      check("sweep_accepts", 32'(idx), 32'd20);
      check("sweep_rsp_count", 32'(n_rsp), 32'd20);
      drain();

      // Reset with two reads in flight and one FIFO entry.
      sel       = 1'b0;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_addr = AW'($urandom_range(0, 127));
         step();
         check("mf_accept", 32'(acc), 32'd1);
      end
      req_valid = 1'b0;
      check("mf_rsp_valid_pre", 32'(o_rsp_valid), 32'd1);
      check("mf_busy_pre", 32'(o_busy), 32'd1);
      rstn = 1'b0;
      #1;
      check("mf_rsp_valid_rst", 32'(o_rsp_valid), 32'd0);
      check("mf_busy_rst", 32'(o_busy), 32'd0);
      check("mf_req_ready_rst", 32'(o_req_ready), 32'd0);
      check("mf_ce_rst", 32'(o_ce), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rstn      = 1'b1;
      rsp_ready = 1'b1;
      repeat (8) begin
         step();
         check("mf_no_rsp", 32'(o_rsp_valid), 32'd0);
      end
      check("mf_busy_post", 32'(o_busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
